// File: rtl/fixed_pkg.sv
// fixed_pkg: shared definitions for the signed Q16.16 fixed-point datapath.
//   FIXED_WIDTH / FIXED_FRAC_BITS : default operand width and fractional bits
//   fixed_t                       : Q16.16 container type
//   FIXED_MAX / FIXED_MIN_SYM     : symmetric saturation limits
//   div_state_t                   : sequential divider FSM states
package fixed_pkg;

    localparam int unsigned FIXED_WIDTH     = 32;
    localparam int unsigned FIXED_FRAC_BITS = 16;

    typedef logic [31:0] fixed_t;

    localparam fixed_t FIXED_MAX     = 32'h7FFF_FFFF;
    localparam fixed_t FIXED_MIN_SYM = 32'h8000_0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/fixed_div_step.sv
// div_step: one radix-2 restoring-division step (combinational).
//   rem_in   : partial remainder, always < divisor
//   bit_in   : next dividend bit shifted into the remainder
//   divisor  : divisor magnitude (unsigned)
//   rem_out  : updated partial remainder
//   q_bit    : quotient bit produced by this step
module div_step
    import fixed_pkg::*;
#(
    parameter int unsigned WIDTH = FIXED_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // One extra bit: the shifted remainder can reach 2*divisor-1.
    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {1'b0, divisor});
        // When subtracting, the difference is below the divisor, so the
        // low WIDTH bits carry the whole result.
        rem_out = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/fixed_div.sv
// fixed_div: sequential signed Q16.16 divider, out = (dividend << FRAC_BITS) / divisor.
// Sign-magnitude: divide magnitudes, truncate toward zero, re-apply sign.
// Radix-2 restoring, one quotient bit per clock, valid/ready on both sides.
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   in_valid/in_ready          : operand handshake (in_ready high only in IDLE)
//   in_dividend, in_divisor    : Q16.16 operands
//   out_valid/out_ready        : result handshake (result held until accepted)
//   out_quotient               : Q16.16 result
//   out_div_zero, out_overflow : status flags, valid with out_valid
// Build option FIXED_DIV_SAT_EN: saturate overflow and divide-by-zero results
// to the symmetric limits instead of wrapping / returning zero.
module fixed_div
    import fixed_pkg::*;
#(
    parameter int unsigned WIDTH     = FIXED_WIDTH,
    parameter int unsigned FRAC_BITS = FIXED_FRAC_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic             out_div_zero,
    output logic             out_overflow
);

    localparam int unsigned ITERS = WIDTH + FRAC_BITS;
    localparam int unsigned CNT_W = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS);

`ifdef FIXED_DIV_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
`endif

    div_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ITERS-1:0]  dvd_q, dvd_d;
    logic [ITERS-1:0]  quot_q, quot_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  mag_b_q, mag_b_d;
    logic              sign_q, sign_d;
    logic [WIDTH-1:0]  out_quotient_q, out_quotient_d;
    logic              out_div_zero_q, out_div_zero_d;
    logic              out_overflow_q, out_overflow_d;

    logic [WIDTH-1:0]  step_rem;
    logic              step_qbit;
    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;
    logic              accept;
    logic              ovf;
    logic [WIDTH-1:0]  q_low;
    logic [WIDTH-1:0]  q_signed;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[ITERS-1]),
        .divisor (mag_b_q),
        .rem_out (step_rem),
        .q_bit   (step_qbit)
    );

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_quotient = out_quotient_q;
    assign out_div_zero = out_div_zero_q;
    assign out_overflow = out_overflow_q;

    always_comb begin
        accept = in_valid && (state_q == IDLE);
        // Two's-complement magnitude as unsigned: the most negative value maps to 2^(WIDTH-1).
        mag_a  = in_dividend[WIDTH-1] ? (~in_dividend + 1'b1) : in_dividend;
        mag_b  = in_divisor[WIDTH-1]  ? (~in_divisor + 1'b1)  : in_divisor;

        // Any quotient bit at or above the sign position makes the magnitude unrepresentable.
        ovf      = |quot_q[ITERS-1:WIDTH-1];
        q_low    = quot_q[WIDTH-1:0];
        q_signed = sign_q ? (~q_low + 1'b1) : q_low;
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        dvd_d          = dvd_q;
        quot_d         = quot_q;
        rem_d          = rem_q;
        mag_b_d        = mag_b_q;
        sign_d         = sign_q;
        out_quotient_d = out_quotient_q;
        out_div_zero_d = out_div_zero_q;
        out_overflow_d = out_overflow_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sign_d  = in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1];
                    mag_b_d = mag_b;
                    dvd_d   = {mag_a, {FRAC_BITS{1'b0}}};
                    quot_d  = '0;
                    rem_d   = '0;
                    cnt_d   = '0;
                    if (in_divisor == '0) begin
                        out_div_zero_d = 1'b1;
                        out_overflow_d = 1'b0;
`ifdef FIXED_DIV_SAT_EN
                        out_quotient_d = in_dividend[WIDTH-1] ? SAT_NEG : SAT_POS;
`else
                        out_quotient_d = '0;
`endif
                        state_d        = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                // ITERS shifting steps, then one formatting cycle that enters DONE.
                if (cnt_q == LAST_CNT) begin
                    out_div_zero_d = 1'b0;
                    out_overflow_d = ovf;
`ifdef FIXED_DIV_SAT_EN
                    out_quotient_d = ovf ? (sign_q ? SAT_NEG : SAT_POS) : q_signed;
`else
                    out_quotient_d = q_signed;
`endif
                    state_d        = DONE;
                end else begin
                    rem_d  = step_rem;
                    quot_d = {quot_q[ITERS-2:0], step_qbit};
                    dvd_d  = {dvd_q[ITERS-2:0], 1'b0};
                    cnt_d  = cnt_q + 1'b1;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            dvd_q          <= '0;
            quot_q         <= '0;
            rem_q          <= '0;
            mag_b_q        <= '0;
            sign_q         <= 1'b0;
            out_quotient_q <= '0;
            out_div_zero_q <= 1'b0;
            out_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dvd_q          <= dvd_d;
            quot_q         <= quot_d;
            rem_q          <= rem_d;
            mag_b_q        <= mag_b_d;
            sign_q         <= sign_d;
            out_quotient_q <= out_quotient_d;
            out_div_zero_q <= out_div_zero_d;
            out_overflow_q <= out_overflow_d;
        end
    end

endmodule

// File: tb/tb_fixed_div.sv
// tb_fixed_div: randomized and directed checks of fixed_div against a
// plain-arithmetic model of signed Q16.16 division (truncation toward zero).
module tb_fixed_div;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_dividend = '0;
    logic [31:0] in_divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_quotient;
    logic        out_div_zero;
    logic        out_overflow;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    fixed_div #(
        .WIDTH     (32),
        .FRAC_BITS (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_div_zero (out_div_zero),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer division of magnitudes, then sign and formatting.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic dz, output logic ov);
        longint sa, sb, ma, mb, qq;
        logic [31:0] low;
        logic        neg;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sb < 0) ? -sb : sb;
        neg = (sa < 0) != (sb < 0);
        if (mb == 0) begin
            dz = 1'b1;
            ov = 1'b0;
`ifdef FIXED_DIV_SAT_EN
            q = (sa < 0) ? 32'h8000_0001 : 32'h7FFF_FFFF;
`else
            q = 32'h0;
`endif
        end else begin
            dz  = 1'b0;
            qq  = (ma * 65536) / mb;
            ov  = (qq >= 64'sd2147483648);
            low = 32'(qq);
            q   = neg ? (32'h0 - low) : low;
`ifdef FIXED_DIV_SAT_EN
            if (ov) q = neg ? 32'h8000_0001 : 32'h7FFF_FFFF;
`endif
        end
    endfunction

    // Called #1 after a rising edge with the DUT idle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] eq;
        logic        edz, eov;
        int          lat;
        int          exp_lat;
        model(a, b, eq, edz, eov);
        exp_lat = (b == 32'h0) ? 0 : 49;
        check("in_ready_idle", 48'(in_ready), 48'h1);
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        // Junk requests while busy must be ignored.
        while (!out_valid && lat < 200) begin
            in_valid    = ($urandom_range(0, 1) == 1);
            in_dividend = $urandom;
            in_divisor  = $urandom;
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", 48'(lat), 48'(exp_lat));
        if (!out_valid) return;
        check("quotient", 48'(out_quotient), 48'(eq));
        check("div_zero", 48'(out_div_zero), 48'(edz));
        check("overflow", 48'(out_overflow), 48'(eov));
        check("in_ready_busy", 48'(in_ready), 48'h0);
        repeat (hold) begin
            in_valid    = 1'b1;
            in_dividend = $urandom;
            in_divisor  = $urandom;
            @(posedge clk);
            #1;
            check("hold_valid", 48'(out_valid), 48'h1);
            check("hold_quotient", 48'(out_quotient), 48'(eq));
            check("hold_flags", 48'({out_div_zero, out_overflow}), 48'({edz, eov}));
            check("hold_in_ready", 48'(in_ready), 48'h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_valid", 48'(out_valid), 48'h0);
        check("release_ready", 48'(in_ready), 48'h1);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        seen_valid;

        #2 rst = 1'b1;
        #2;
        check("rst_valid", 48'(out_valid), 48'h0);
        check("rst_ready", 48'(in_ready), 48'h1);
        check("rst_quotient", 48'(out_quotient), 48'h0);
        check("rst_flags", 48'({out_div_zero, out_overflow}), 48'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(32'h0003_0000, 32'h0002_0000, 0);
        run_op(32'hFFFF_0000, 32'h0004_0000, 1);
        run_op(32'h0001_0000, 32'h0003_0000, 0);
        run_op(32'h0001_0000, 32'h0000_0000, 2);
        run_op(32'hFFFF_0000, 32'h0000_0000, 0);
        run_op(32'h0000_0000, 32'h0000_0000, 0);
        run_op(32'h7FFF_0000, 32'h0000_0100, 0);
        run_op(32'h8000_0000, 32'h0000_0100, 0);
        run_op(32'h8000_0000, 32'h8000_0000, 0);
        run_op(32'h0000_0000, 32'hFFFE_0000, 0);
        run_op(32'h0005_0000, 32'hFFFE_0000, 0);
        run_op(32'h0123_4567, 32'h0001_0000, 10);

        // Reset partway through a calculation: no result may appear.
        in_valid    = 1'b1;
        in_dividend = 32'h0005_0000;
        in_divisor  = 32'h0003_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_valid", 48'(out_valid), 48'h0);
        check("midrst_ready", 48'(in_ready), 48'h1);
        check("midrst_quotient", 48'(out_quotient), 48'h0);
        @(negedge clk) rst = 1'b0;
        seen_valid = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("midrst_no_result", 48'(seen_valid), 48'h0);
        run_op(32'h0002_0000, 32'h0001_0000, 0);

        for (int unsigned i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom; b = 32'($urandom_range(0, 1023)) - 32'd512; end
                2: begin a = $urandom; b = 32'h0; end
                3: begin a = 32'h8000_0000; b = $urandom; end
                default: begin
                    a = 32'($signed($urandom_range(0, 32'hF_FFFF)) - 32'sh8_0000);
                    b = 32'($signed($urandom_range(1, 32'hF_FFFF)) - 32'sh8_0000);
                end
            endcase
            run_op(a, b, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
